ring_counter_gen: RTL and testbench
===================================

Name: ring_counter_gen

Overview:
Parametrised shift-register counter. It generates one-hot ring or Johnson (twisted-ring) sequences of configurable width, with run-time mode, direction, enable and parallel load. It also produces a wrap pulse and flags illegal states. It sits beside the timing and sequencing logic as the team's general-purpose phase or strobe generator, and replaces fixed 4-bit ring counters.

Parameters:
- WIDTH, 4, number of state bits; legal range 2..32.
- SEED_POS, 0, bit index set in the ring-mode seed (one-hot 1<<SEED_POS); must be < WIDTH.

Ports:
- clk  input  1  clock, all state updates on rising edge
- rst  input  1  reset, synchronous, active-low
- en  input  1  advance one step per cycle when high
- mode  input  1  0 = ring (one-hot rotate), 1 = Johnson (inverted feedback)
- dir  input  1  0 = shift toward MSB, 1 = shift toward LSB
- load  input  1  parallel load strobe
- load_val  input  WIDTH  value written on load
- out  output  WIDTH  counter state (registered)
- wrap  output  1  registered pulse: out returned to seed via a shift
- illegal  output  1  combinational: out is not a legal state for current mode

Behaviour:
- Seed is a function of mode: SEED_RING = 1<<SEED_POS; SEED_JOHN = all zeros.
- Reset: when rst=0 at a clock edge, out <= seed(mode), wrap <= 0, and mode_q <= mode. Reset applies regardless of the other inputs.
- Priority per edge, highest first: reset, load, mode change, shift, hold.
- Load: out <= load_val; wrap <= 0; the value is accepted even if illegal.
- Mode change: when mode != mode_q and load=0, out <= seed(mode) and wrap <= 0. mode_q tracks mode every cycle.
- Shift (en=1, no higher event):
  - Ring, dir=0: out <= {out[W-2:0], out[W-1]}.
  - Ring, dir=1: out <= {out[0], out[W-1:1]}.
  - Johnson, dir=0: out <= {out[W-2:0], ~out[W-1]}.
  - Johnson, dir=1: out <= {~out[0], out[W-1:1]}.
- Hold: en=0 and no higher event leaves out unchanged and sets wrap <= 0.
- Latency: one cycle from en to updated out. wrap is registered alongside out, so wrap=1 in the same cycle that out shows the seed reached by a shift. wrap <= (next_out == seed(mode)) on a shift step, else 0.
- Period: WIDTH steps in ring mode, 2*WIDTH steps in Johnson mode. dir may toggle on any cycle; the sequence reverses from the current state with no bubble.
- Legal states:
  - Ring: exactly one bit set.
  - Johnson: out is 0*1* or 1*0* read MSB to LSB, i.e. at most one 0->1 or 1->0 transition between adjacent bits, not counting the wrap-around pair.
- illegal is combinational from out and mode_q, and is 0 after reset.
- Boundaries:
  - WIDTH=2 Johnson sequence is 00,01,11,10.
  - Load and en together: the load wins and no shift happens that cycle.
  - rst low mid-sequence re-seeds on the next edge.
  - A ring state of all zeros is illegal and stays all zeros when shifted (without the optional feature).

Optional Feature:
- RING_CNT_SELFCORRECT_EN defined: on a shift step with illegal=1, out <= seed(mode) instead of the shifted value, and wrap <= 1 for that cycle. The counter therefore recovers within one enabled cycle.
- Undefined: illegal is a status flag only and the shift proceeds on the corrupted value.
- Load, reset and priority behaviour are identical in both builds.

Decomposition:
- Shared package ring_cnt_pkg:
  - localparam constants MODE_RING=1'b0, MODE_JOHN=1'b1, DIR_UP=1'b0, DIR_DN=1'b1.
  - Function seed_of(mode, width, seed_pos).
- One natural sub-module, ring_cnt_legal_chk: combinational legality checker taking out and mode and returning illegal. It is reused by the bench scoreboard.

Test Plan:
- WIDTH=4, mode=0, dir=0, en=1 after reset: out = 0001,0010,0100,1000,0001; wrap=1 only on the cycle the second 0001 appears.
- WIDTH=4, mode=1, dir=0, en=1: out = 0000,0001,0011,0111,1111,1110,1100,1000,0000; wrap on return to 0000; dir flipped at 0111 gives 0011 next.
- Load 0110 in ring mode: illegal=1. Without the macro the next en gives 1100. With RING_CNT_SELFCORRECT_EN the next en gives 0001 and wrap=1.
- Load=1 and en=1 together with load_val=0100: out=0100 next cycle, no shift. en=0 for 3 cycles: out holds 0100 and wrap=0.
- Mode toggled 0->1 while out=0100: out=0000 next edge, and the Johnson sequence continues from there.
- rst=0 asserted mid-Johnson at 0111 with en=1 and load=1: out=0000, wrap=0 next edge. Repeat with WIDTH=8 and SEED_POS=3: ring reset gives 00001000.

Source files
------------

// File: rtl/ring_cnt_pkg.sv
// ring_cnt_pkg: mode/direction constants and the seed helper shared by the ring counter and its bench
package ring_cnt_pkg;
  localparam logic MODE_RING = 1'b0;
  localparam logic MODE_JOHN = 1'b1;
  localparam logic DIR_UP = 1'b0;
  localparam logic DIR_DN = 1'b1;
  function automatic logic [31:0] seed_of(input logic mode, input int width, input int seed_pos);
    logic [31:0] mask;
    mask = (width >= 32) ? '1 : (32'd1 << width) - 32'd1;
    return (mode == MODE_JOHN) ? 32'd0 : (32'd1 << seed_pos) & mask;
  endfunction
endpackage

// File: rtl/ring_counter_gen_if.sv
// ring_counter_gen_if: control and status bundle of ring_counter_gen (master drives en/mode/dir/load/load_val, slave returns out/wrap/illegal)
interface ring_counter_gen_if #(parameter int WIDTH = 4);
  logic en;
  logic mode;
  logic dir;
  logic load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] out;
  logic wrap;
  logic illegal;
  modport master(output en, mode, dir, load, load_val, input out, wrap, illegal);
  modport slave(input en, mode, dir, load, load_val, output out, wrap, illegal);
endinterface

// File: rtl/ring_cnt_legal_chk.sv
// ring_cnt_legal_chk: flags out_i as illegal_o when it is not one-hot (ring) or not 0*1*/1*0* (Johnson)
module ring_cnt_legal_chk
  import ring_cnt_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] out_i,
  input  logic             mode_i,
  output logic             illegal_o
);
  logic [WIDTH-2:0] edges;
  always_comb begin
    edges = out_i[WIDTH-1:1] ^ out_i[WIDTH-2:0];
    illegal_o = (mode_i == MODE_JOHN) ? ($countones(edges) > 1) : ($countones(out_i) != 1);
  end
endmodule

// File: rtl/ring_counter_gen.sv
// ring_counter_gen: ring/Johnson shift counter (clk, active-low sync rst, bus slave), self-correction under RING_CNT_SELFCORRECT_EN
module ring_counter_gen
  import ring_cnt_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int SEED_POS = 0
) (
  input logic clk,
  input logic rst,
  ring_counter_gen_if.slave bus
);
  logic [WIDTH-1:0] out_q, out_d, seed, shifted, step;
  logic wrap_q, wrap_d, mode_q, illegal, fb, step_wrap;
  ring_cnt_legal_chk #(.WIDTH(WIDTH)) u_chk (.out_i(out_q), .mode_i(mode_q), .illegal_o(illegal));
  always_comb begin
    seed = WIDTH'(seed_of(bus.mode, WIDTH, SEED_POS));
    fb = ((bus.dir == DIR_DN) ? out_q[0] : out_q[WIDTH-1]) ^ (bus.mode == MODE_JOHN);
    shifted = (bus.dir == DIR_DN) ? {fb, out_q[WIDTH-1:1]} : {out_q[WIDTH-2:0], fb};
`ifdef RING_CNT_SELFCORRECT_EN
    step = illegal ? seed : shifted;
    step_wrap = illegal || (shifted == seed);
`else
    step = shifted;
    step_wrap = shifted == seed;
`endif
    out_d = bus.load ? bus.load_val : (bus.mode != mode_q) ? seed : bus.en ? step : out_q;
    wrap_d = !bus.load && (bus.mode == mode_q) && bus.en && step_wrap;
  end
  always_ff @(posedge clk) begin
    out_q <= rst ? out_d : seed;
    wrap_q <= rst && wrap_d;
    mode_q <= bus.mode;
  end
  assign bus.out = out_q;
  assign bus.wrap = wrap_q;
  assign bus.illegal = illegal;
endmodule

// File: tb/tb_ring_counter_gen.sv
// tb_ring_counter_gen: directed plus random stimulus on a 4-bit and an 8-bit (seed bit 3) counter against an arithmetic reference model
module tb_ring_counter_gen;
  logic clk = 1'b0;
  logic rst, en, mode, dir, load;
  logic [3:0] lva;
  logic [7:0] lvb;
  int n_chk = 0;
  int n_fail = 0;
  int W[2] = '{4, 8};
  int SP[2] = '{0, 3};
  logic [31:0] m_out[2];
  logic m_wrap[2];
  logic m_mq[2];
  always #5 clk = ~clk;
  ring_counter_gen_if #(.WIDTH(4)) ia ();
  ring_counter_gen_if #(.WIDTH(8)) ib ();
  assign ia.en = en;
  assign ia.mode = mode;
  assign ia.dir = dir;
  assign ia.load = load;
  assign ia.load_val = lva;
  assign ib.en = en;
  assign ib.mode = mode;
  assign ib.dir = dir;
  assign ib.load = load;
  assign ib.load_val = lvb;
  ring_counter_gen #(.WIDTH(4), .SEED_POS(0)) dut_a (.clk(clk), .rst(rst), .bus(ia));
  ring_counter_gen #(.WIDTH(8), .SEED_POS(3)) dut_b (.clk(clk), .rst(rst), .bus(ib));
  function automatic logic [31:0] mask_of(input int w);
    return (32'd1 << w) - 32'd1;
  endfunction
  function automatic logic [31:0] seed_m(input int i, input logic md);
    return md ? 32'd0 : 32'd1 << SP[i];
  endfunction
  function automatic logic bad(input int i, input logic [31:0] v, input logic md);
    logic [31:0] c;
    c = mask_of(W[i]) ^ v;
    if (!md) return v == 0 || (v & (v - 1)) != 0;
    return !((((v + 1) & v) == 0) || (((c + 1) & c) == 0));
  endfunction
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    logic [31:0] nxt[2];
    logic nw[2];
    for (int i = 0; i < 2; i++) begin
      logic [31:0] v, sd, sh, lv;
      logic fbit;
      v = m_out[i];
      sd = seed_m(i, mode);
      lv = (i == 0) ? 32'(lva) : 32'(lvb);
      fbit = 1'((dir ? v : v >> (W[i] - 1)) & 32'd1) ^ mode;
      sh = dir ? (v >> 1) | (32'(fbit) << (W[i] - 1)) : ((v << 1) | 32'(fbit)) & mask_of(W[i]);
      nw[i] = 1'b0;
      if (!rst) nxt[i] = seed_m(i, mode);
      else if (load) nxt[i] = lv;
      else if (mode != m_mq[i]) nxt[i] = sd;
      else if (en) begin
`ifdef RING_CNT_SELFCORRECT_EN
        if (bad(i, v, m_mq[i])) begin
          nxt[i] = sd;
          nw[i] = 1'b1;
        end else
`endif
        begin
          nxt[i] = sh;
          nw[i] = sh == sd;
        end
      end else nxt[i] = v;
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      m_out[i] = nxt[i];
      m_wrap[i] = nw[i];
      m_mq[i] = mode;
    end
    check("a_out", 32'(ia.out), m_out[0]);
    check("a_wrap", 32'(ia.wrap), 32'(m_wrap[0]));
    check("a_illegal", 32'(ia.illegal), 32'(bad(0, m_out[0], m_mq[0])));
    check("b_out", 32'(ib.out), m_out[1]);
    check("b_wrap", 32'(ib.wrap), 32'(m_wrap[1]));
    check("b_illegal", 32'(ib.illegal), 32'(bad(1, m_out[1], m_mq[1])));
  endtask
  initial begin
    rst = 0; en = 0; mode = 0; dir = 0; load = 0; lva = 0; lvb = 0;
    for (int i = 0; i < 2; i++) begin
      m_out[i] = 0; m_wrap[i] = 0; m_mq[i] = 0;
    end
    tick();
    check("rst_a", 32'(ia.out), 32'h1);
    check("rst_b", 32'(ib.out), 32'h08);
    check("rst_ill", 32'(ia.illegal), 0);
    rst = 1; en = 1;
    repeat (3) tick();
    check("ring3", 32'(ia.out), 32'b1000);
    tick();
    check("ring_ret", 32'(ia.out), 32'b0001);
    check("ring_wrap", 32'(ia.wrap), 1);
    mode = 1;
    tick();
    check("john_seed", 32'(ia.out), 0);
    repeat (3) tick();
    check("john3", 32'(ia.out), 32'b0111);
    dir = 1;
    tick();
    check("john_rev", 32'(ia.out), 32'b0011);
    dir = 0;
    repeat (10) tick();
    mode = 0;
    tick();
    load = 1; lva = 4'b0110;
    tick();
    check("ld_ill", 32'(ia.illegal), 1);
    load = 0;
    tick();
`ifdef RING_CNT_SELFCORRECT_EN
    check("fix_out", 32'(ia.out), 32'b0001);
    check("fix_wrap", 32'(ia.wrap), 1);
`else
    check("bad_shift", 32'(ia.out), 32'b1100);
`endif
    load = 1; en = 1; lva = 4'b0100;
    tick();
    check("ld_en", 32'(ia.out), 32'b0100);
    load = 0; en = 0;
    repeat (3) tick();
    check("hold", 32'(ia.out), 32'b0100);
    check("hold_wrap", 32'(ia.wrap), 0);
    mode = 1;
    tick();
    check("mode_sw", 32'(ia.out), 0);
    en = 1;
    repeat (3) tick();
    check("john_mid", 32'(ia.out), 32'b0111);
    rst = 0; load = 1; lva = 4'hf;
    tick();
    check("rst_mid", 32'(ia.out), 0);
    check("rst_mid_wrap", 32'(ia.wrap), 0);
    load = 0; mode = 0;
    tick();
    check("rst_b8", 32'(ib.out), 32'h08);
    rst = 1;
    repeat (400) begin
      rst = $urandom_range(0, 99) >= 3;
      load = $urandom_range(0, 9) == 0;
      if ($urandom_range(0, 19) == 0) mode = ~mode;
      en = $urandom_range(0, 9) < 7;
      dir = 1'($urandom_range(0, 1));
      lva = 4'($urandom);
      lvb = 8'($urandom);
      tick();
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
